// File: rtl/four_bank_mem_pkg.sv
// Shared constants and request classification for the four-bank memory responder.
package four_bank_mem_pkg;

  localparam int NUM_BANKS = 4;
  localparam int BANK_LSB  = 1;
  localparam int BANK_MSB  = 2;
  localparam int BANK_W    = BANK_MSB - BANK_LSB + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ILLEGAL  = 2'd1,
    CONFLICT = 2'd2,
    ACCEPT   = 2'd3
  } req_class_e;

endpackage

// File: rtl/four_bank_mem_responder_bank_timer.sv
// Per-bank occupancy timer: loads BANK_LAT on accept, counts down to zero.
module bank_timer #(
  parameter int BANK_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy
);

  localparam int CNT_W = $clog2(BANK_LAT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(BANK_LAT);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/four_bank_mem_responder.sv
// Four-bank main-memory responder: banked storage, per-bank busy timers and a
// two-stage read return pipeline serving the cache miss path.
module four_bank_mem_responder
  import four_bank_mem_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int BANK_LAT       = 4,
  parameter int WORDS_PER_BANK = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd,
  input  logic                 wr,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data_in,
  output logic [DATA_W-1:0]    data_out,
  output logic                 data_valid,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  localparam int IDX_W = (WORDS_PER_BANK > 1) ? $clog2(WORDS_PER_BANK) : 1;

  logic [BANK_W-1:0]    bank;
  logic [ADDR_W-4:0]    word_addr;
  logic [IDX_W-1:0]     idx;
  logic [NUM_BANKS-1:0] bank_load;
  logic                 accept;
  req_class_e           req_class;

  logic [DATA_W-1:0] mem [NUM_BANKS][WORDS_PER_BANK];
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;

  assign bank      = addr[BANK_MSB:BANK_LSB];
  assign word_addr = addr[ADDR_W-1:3];
  assign idx       = IDX_W'(word_addr % (ADDR_W-3)'(WORDS_PER_BANK));

  // Requests seen while rst is low are treated as idle and never take effect.
  always_comb begin
    req_class = IDLE;
    if (rst && (rd || wr)) begin
      if ((rd && wr) || addr[0]) begin
        req_class = ILLEGAL;
      end else if (busy[bank]) begin
        req_class = CONFLICT;
      end else begin
        req_class = ACCEPT;
      end
    end
  end

  // Handshake: a legal request is taken on the rising edge where stall=0;
  // while stall=1 the requester holds rd/wr/addr/data_in unchanged.
  assign stall  = (req_class == CONFLICT);
  assign accept = (req_class == ACCEPT);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_load[b] = accept && (bank == BANK_W'(b));

    bank_timer #(
      .BANK_LAT(BANK_LAT)
    ) u_timer (
      .clk (clk),
      .rst (rst),
      .load(bank_load[b]),
      .busy(busy[b])
    );
  end

  // Storage and stage-1 read capture are deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      mem[bank][idx] <= data_in;
    end
    if (accept && rd) begin
      s1_data <= mem[bank][idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid   <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
      err        <= 1'b0;
    end else begin
      s1_valid   <= accept && rd;
      data_valid <= s1_valid;
      if (s1_valid) begin
        data_out <= s1_data;
      end
      err <= (req_class == ILLEGAL);
    end
  end

endmodule
